// File: rtl/mem_arb.sv
// Two-port Avalon-MM arbiter in front of a single memory slave port.
// Round-robin grant with a per-grant transfer cap; owner never changes while reads are in flight.
module mem_arb #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned OUTST_WIDTH = 4,
  parameter int unsigned MAX_BURST   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdataready,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdataready,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [BE_WIDTH-1:0]   s_byteenable,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_readdataready,
  input  logic                  s_waitrequest
);

  localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [OUTST_WIDTH-1:0] OUTST_MAX = '1;
  localparam logic [BURST_WIDTH-1:0] BURST_CAP = BURST_WIDTH'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [OUTST_WIDTH-1:0] outst, outst_nxt;
  logic [BURST_WIDTH-1:0] burst_cnt, burst_nxt;
  logic                   owner, owner_nxt;
  logic                   granted, granted_nxt;

  logic req0, req1, sel_read, sel_write, sel_req, other_req;
  logic in_grant, read_block, cap_hit, sel_wait, acc_read, accepted;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign sel_read  = owner ? m1_read  : m0_read;
  assign sel_write = owner ? m1_write : m0_write;
  assign sel_req   = owner ? req1 : req0;
  assign other_req = owner ? req0 : req1;
  assign in_grant  = (state == GRANT0) || (state == GRANT1);

  // Address/data always follow the owner; only the strobes are gated.
  assign s_address    = owner ? m1_address    : m0_address;
  assign s_byteenable = owner ? m1_byteenable : m0_byteenable;
  assign s_writedata  = owner ? m1_writedata  : m0_writedata;
  assign m0_readdata  = s_readdata;
  assign m1_readdata  = s_readdata;

  // Returns go to the last granted master; before any grant they go to master 0.
  assign m0_readdataready = s_readdataready & ~(owner & granted);
  assign m1_readdataready = s_readdataready &  (owner & granted);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      outst     <= '0;
      burst_cnt <= '0;
      owner     <= 1'b1;
      granted   <= 1'b0;
    end else begin
      state     <= state_nxt;
      outst     <= outst_nxt;
      burst_cnt <= burst_nxt;
      owner     <= owner_nxt;
      granted   <= granted_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    granted_nxt = granted;
    burst_nxt   = burst_cnt;
    outst_nxt   = outst;

    read_block = sel_read & (outst == OUTST_MAX);
    // Once the cap is reached with a competitor waiting, no further transfer is accepted.
    cap_hit    = (burst_cnt == BURST_CAP) & other_req;
    s_read     = in_grant & sel_read & ~read_block & ~cap_hit;
    s_write    = in_grant & sel_write & ~cap_hit;
    sel_wait   = s_waitrequest | read_block | cap_hit;
    m0_waitrequest = (state != GRANT0) | sel_wait;
    m1_waitrequest = (state != GRANT1) | sel_wait;
    acc_read   = s_read & ~s_waitrequest;
    accepted   = (s_read | s_write) & ~s_waitrequest;

    if (acc_read && !s_readdataready) begin
      outst_nxt = outst + OUTST_WIDTH'(1);
    end else if (!acc_read && s_readdataready && (outst != '0)) begin
      outst_nxt = outst - OUTST_WIDTH'(1);
    end

    case (state)
      IDLE: begin
        if (req0 && (!req1 || owner)) begin
          state_nxt   = GRANT0;
          owner_nxt   = 1'b0;
          granted_nxt = 1'b1;
          burst_nxt   = '0;
        end else if (req1) begin
          state_nxt   = GRANT1;
          owner_nxt   = 1'b1;
          granted_nxt = 1'b1;
          burst_nxt   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (accepted && (burst_cnt != BURST_CAP)) begin
          burst_nxt = burst_cnt + BURST_WIDTH'(1);
        end
        if (!sel_req || cap_hit) begin
          state_nxt = (outst_nxt != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (outst == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: bench-side memory model, master drivers and in-order read return slave.
module tb_mem_arb;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned OW = 2;
  localparam int unsigned MB = 8;
  localparam int OMAX = 3;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    int            gap;
  } txn_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic [AW-1:0] m_addr [2];
  logic [BW-1:0] m_be [2];
  logic [DW-1:0] m_wdata [2];
  logic [1:0]    m_read, m_write;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_rdr, m1_rdr, m0_wait, m1_wait;
  logic [AW-1:0] s_address;
  logic [BW-1:0] s_be;
  logic          s_read, s_write, s_rdr, s_wait;
  logic [DW-1:0] s_wdata, s_rdata;

  mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .OUTST_WIDTH(OW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m_addr[0]), .m0_byteenable(m_be[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
    .m0_writedata(m_wdata[0]), .m0_readdata(m0_rdata), .m0_readdataready(m0_rdr), .m0_waitrequest(m0_wait),
    .m1_address(m_addr[1]), .m1_byteenable(m_be[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
    .m1_writedata(m_wdata[1]), .m1_readdata(m1_rdata), .m1_readdataready(m1_rdr), .m1_waitrequest(m1_wait),
    .s_address(s_address), .s_byteenable(s_be), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_wdata), .s_readdata(s_rdata), .s_readdataready(s_rdr), .s_waitrequest(s_wait)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] slv_mem [64];
  logic [DW-1:0] exp0 [$];
  logic [DW-1:0] exp1 [$];
  txn_t cmd0 [$];
  txn_t cmd1 [$];
  ret_t pq [$];
  int   acc_log [$];
  int   wait_log [$];
  txn_t cur [2];
  bit [1:0] busy;
  int   wait_cyc [2];
  int   cyc = 0;
  int   b_outst = 0;
  int   last_due = 0;
  int   last_m = -1;
  int   ws_pct = 0;
  int   ret_pct = 100;
  int   lat_min = 2;
  int   lat_max = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < int'(BW); b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int count_m(input int base, input int m);
    int c = 0;
    for (int i = base; i < acc_log.size(); i++) if (acc_log[i] == m) c++;
    return c;
  endfunction

  task automatic add_txn(input int n, input bit wr, input int addr, input logic [DW-1:0] data,
                         input logic [BW-1:0] be, input int gap);
    txn_t t;
    t.wr = wr; t.addr = AW'(addr); t.data = data; t.be = be; t.gap = gap;
    if (n == 0) cmd0.push_back(t); else cmd1.push_back(t);
  endtask

  // Monitor: every read return is matched against the issuing master's expected queue.
  always @(negedge clock) begin
    if (m0_rdr) begin
      if (exp0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rdr0_unexpected: got return data %0h, required no pending m0 read", m0_rdata);
      end else check("rdata0", 32'(m0_rdata), 32'(exp0.pop_front()));
    end
    if (m1_rdr) begin
      if (exp1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rdr1_unexpected: got return data %0h, required no pending m1 read", m1_rdata);
      end else check("rdata1", 32'(m1_rdata), 32'(exp1.pop_front()));
    end
  end

  task automatic observe(input bit chk_idle);
    logic       w;
    logic [5:0] a;
    bit         acc_rd;
    int         due;
    @(negedge clock);
    if (chk_idle) begin
      check("idle_s_read", 32'(s_read), 32'd0);
      check("idle_s_write", 32'(s_write), 32'd0);
      check("idle_wait0", 32'(m0_wait), 32'd1);
      check("idle_wait1", 32'(m1_wait), 32'd1);
      check("idle_rdr0", 32'(m0_rdr), 32'(s_rdr));
      check("idle_rdr1", 32'(m1_rdr), 32'd0);
    end
    check("single_grant", 32'(m0_wait | m1_wait), 32'd1);
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? m0_wait : m1_wait;
      if (busy[n] && !w) begin
        if (last_m >= 0 && last_m != n) check("switch_drained", 32'(b_outst), 32'd0);
        last_m = n;
        a = cur[n].addr[5:0];
        if (cur[n].wr) ref_mem[a] = merge(ref_mem[a], cur[n].data, cur[n].be);
        else if (n == 0) exp0.push_back(ref_mem[a]);
        else exp1.push_back(ref_mem[a]);
        acc_log.push_back(n);
        wait_log.push_back(wait_cyc[n]);
        busy[n] = 1'b0;
      end else if (busy[n]) wait_cyc[n]++;
    end
    acc_rd = s_read && !s_wait;
    if (acc_rd) begin
      ret_t r;
      check("outst_limit", 32'(b_outst < OMAX), 32'd1);
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due = due; r.data = slv_mem[s_address[5:0]];
      pq.push_back(r);
    end
    if (s_write && !s_wait) slv_mem[s_address[5:0]] = merge(slv_mem[s_address[5:0]], s_wdata, s_be);
    if (acc_rd && !s_rdr) b_outst++;
    else if (!acc_rd && s_rdr && b_outst > 0) b_outst--;
  endtask

  task automatic drive_masters();
    for (int n = 0; n < 2; n++) begin
      if (!busy[n]) begin
        if (n == 0 && cmd0.size() > 0) begin
          if (cmd0[0].gap > 0) cmd0[0].gap = cmd0[0].gap - 1;
          else begin cur[0] = cmd0.pop_front(); busy[0] = 1'b1; wait_cyc[0] = 0; end
        end else if (n == 1 && cmd1.size() > 0) begin
          if (cmd1[0].gap > 0) cmd1[0].gap = cmd1[0].gap - 1;
          else begin cur[1] = cmd1.pop_front(); busy[1] = 1'b1; wait_cyc[1] = 0; end
        end
      end
      if (busy[n]) begin
        m_addr[n] = cur[n].addr; m_be[n] = cur[n].be; m_wdata[n] = cur[n].data;
        m_read[n] = !cur[n].wr; m_write[n] = cur[n].wr;
      end else begin
        m_read[n] = 1'b0; m_write[n] = 1'b0;
      end
    end
  endtask

  task automatic drive_slave();
    ret_t r;
    s_wait = ($urandom_range(99) < ws_pct);
    if (pq.size() > 0 && pq[0].due <= cyc && $urandom_range(99) < ret_pct) begin
      r = pq.pop_front();
      s_rdr = 1'b1; s_rdata = r.data;
    end else begin
      s_rdr = 1'b0; s_rdata = DW'($urandom);
    end
  endtask

  task automatic cycle(input bit chk_idle);
    observe(chk_idle);
    @(posedge clock);
    cyc++;
    #1;
    drive_masters();
    drive_slave();
  endtask

  function automatic bit phase_done();
    return cmd0.size() == 0 && cmd1.size() == 0 && busy == 2'b00 && pq.size() == 0 &&
           exp0.size() == 0 && exp1.size() == 0 && !s_rdr;
  endfunction

  task automatic run_phase(input string name, input int budget);
    int k = 0;
    drive_masters();
    while (!phase_done() && k < budget) begin cycle(1'b0); k++; end
    if (k >= budget) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required completion", name, budget);
    end
    cycle(1'b0);
    cycle(1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    busy = 2'b00; m_read = 2'b00; m_write = 2'b00;
    cmd0.delete(); cmd1.delete();
    cycle(1'b0);
    reset_n = 1'b1;
    pq.delete(); exp0.delete(); exp1.delete();
    b_outst = 0; last_due = 0; last_m = -1;
    s_rdr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = DW'(i * 16'h0101) ^ 16'h1234;
      slv_mem[i] = ref_mem[i];
    end
    reset_n = 1'b0; busy = 2'b00; m_read = 2'b00; m_write = 2'b00;
    for (int n = 0; n < 2; n++) begin m_addr[n] = '0; m_be[n] = '0; m_wdata[n] = '0; wait_cyc[n] = 0; end
    s_wait = 1'b0; s_rdr = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    cycle(1'b1);

    // Single master: four back-to-back reads, two-cycle return latency.
    base = acc_log.size();
    for (int i = 0; i < 4; i++) add_txn(0, 1'b0, i, '0, 2'b11, 0);
    run_phase("single", 100);
    check("single_count0", 32'(count_m(base, 0)), 32'd4);
    check("single_count1", 32'(count_m(base, 1)), 32'd0);
    check("single_first_wait", 32'(wait_log[base]), 32'd1);
    for (int i = 1; i < 4; i++) check("single_b2b_wait", 32'(wait_log[base+i]), 32'd0);
    base = acc_log.size();
    add_txn(1, 1'b0, 5, '0, 2'b11, 0);
    run_phase("m1_after_drain", 100);
    check("m1_after_drain_wait", 32'(wait_log[base]), 32'd1);

    // Tie right after reset: m0 first, m1 after m0 drains, next tie back to m0.
    do_reset();
    base = acc_log.size();
    add_txn(0, 1'b0, 8, '0, 2'b11, 0);
    add_txn(0, 1'b0, 9, '0, 2'b11, 0);
    add_txn(1, 1'b1, 10, 16'h1357, 2'b11, 0);
    run_phase("tie", 100);
    check("tie_first", 32'(acc_log[base]), 32'd0);
    check("tie_second", 32'(acc_log[base+1]), 32'd0);
    check("tie_third", 32'(acc_log[base+2]), 32'd1);
    base = acc_log.size();
    add_txn(0, 1'b0, 10, '0, 2'b11, 0);
    add_txn(1, 1'b0, 8, '0, 2'b11, 0);
    run_phase("tie2", 100);
    check("tie2_first", 32'(acc_log[base]), 32'd0);
    check("tie2_second", 32'(acc_log[base+1]), 32'd1);

    // Burst cap: m1 write squeezed in after exactly MB m0 transfers.
    base = acc_log.size();
    for (int i = 0; i < 12; i++) add_txn(0, 1'b0, 48 + i, '0, 2'b11, 0);
    add_txn(1, 1'b1, 16, 16'hBEEF, 2'b11, 2);
    run_phase("burst", 200);
    check("burst_len", 32'(acc_log.size() - base), 32'd13);
    check("burst_before", 32'(acc_log[base+7]), 32'd0);
    check("burst_switch", 32'(acc_log[base+8]), 32'd1);
    check("burst_after", 32'(acc_log[base+9]), 32'd0);
    check("burst_mem", 32'(slv_mem[16]), 32'hBEEF);

    // Read saturation: with returns withheld only 2^OW-1 reads get through.
    for (int rep = 0; rep < 2; rep++) begin
      base = acc_log.size();
      ret_pct = 0; lat_min = 1; lat_max = 1;
      for (int i = 0; i < 4; i++) add_txn(0, 1'b0, 32 + 4*rep + i, '0, 2'b11, 0);
      drive_masters();
      repeat (8) cycle(1'b0);
      check("sat_count", 32'(count_m(base, 0)), 32'd3);
      check("sat_wait", 32'(m0_wait), 32'd1);
      check("sat_s_read", 32'(s_read), 32'd0);
      ret_pct = 100;
      run_phase("sat_release", 100);
      check("sat_total", 32'(count_m(base, 0)), 32'd4);
    end

    // Reset in DRAIN with three reads outstanding, then a stray return.
    base = acc_log.size();
    ret_pct = 0;
    for (int i = 0; i < 3; i++) add_txn(0, 1'b0, 40 + i, '0, 2'b11, 0);
    drive_masters();
    repeat (6) cycle(1'b0);
    check("drain_count", 32'(count_m(base, 0)), 32'd3);
    check("drain_wait0", 32'(m0_wait), 32'd1);
    check("drain_wait1", 32'(m1_wait), 32'd1);
    do_reset();
    s_rdr = 1'b1; s_rdata = 16'h5A5A; exp0.push_back(16'h5A5A);
    cycle(1'b1);
    base = acc_log.size();
    for (int i = 0; i < 4; i++) add_txn(0, 1'b0, 44 + i, '0, 2'b11, 0);
    drive_masters();
    repeat (8) cycle(1'b0);
    check("post_reset_sat", 32'(count_m(base, 0)), 32'd3);
    ret_pct = 100;
    run_phase("post_reset", 100);

    // Random traffic from both masters against the memory model.
    do_reset();
    ws_pct = 25; ret_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 150; i++) begin
      for (int n = 0; n < 2; n++) begin
        bit wr;
        wr = ($urandom_range(99) < 40);
        add_txn(n, wr, $urandom_range(63), DW'($urandom), wr ? BW'($urandom_range(3)) : 2'b11,
                $urandom_range(3));
      end
    end
    run_phase("random", 20000);
    check("final_exp_empty", 32'(exp0.size() + exp1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
